// File: rtl/vx_mem_tag_remap.sv
// Memory tag remapper: forwards core requests with a compact slot tag on reads and
// restores the original wide tag on responses through a one-entry response register.
module vx_mem_tag_remap #(
  parameter int DATA_SIZE       = 4,
  parameter int ADDR_WIDTH      = 30,
  parameter int FLAGS_WIDTH     = 1,
  parameter int IN_TAG_WIDTH    = 8,
  parameter int NUM_OUTSTANDING = 4,
  parameter int OUT_TAG_WIDTH   = $clog2(NUM_OUTSTANDING)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          core_req_valid,
  input  logic                          core_req_rw,
  input  logic [ADDR_WIDTH-1:0]         core_req_addr,
  input  logic [DATA_SIZE*8-1:0]        core_req_data,
  input  logic [DATA_SIZE-1:0]          core_req_byteen,
  input  logic [FLAGS_WIDTH-1:0]        core_req_flags,
  input  logic [IN_TAG_WIDTH-1:0]       core_req_tag,
  output logic                          core_req_ready,
  output logic                          core_rsp_valid,
  output logic [DATA_SIZE*8-1:0]        core_rsp_data,
  output logic [IN_TAG_WIDTH-1:0]       core_rsp_tag,
  input  logic                          core_rsp_ready,
  output logic                          mem_req_valid,
  output logic                          mem_req_rw,
  output logic [ADDR_WIDTH-1:0]         mem_req_addr,
  output logic [DATA_SIZE*8-1:0]        mem_req_data,
  output logic [DATA_SIZE-1:0]          mem_req_byteen,
  output logic [FLAGS_WIDTH-1:0]        mem_req_flags,
  output logic [OUT_TAG_WIDTH-1:0]      mem_req_tag,
  input  logic                          mem_req_ready,
  input  logic                          mem_rsp_valid,
  input  logic [DATA_SIZE*8-1:0]        mem_rsp_data,
  input  logic [OUT_TAG_WIDTH-1:0]      mem_rsp_tag,
  output logic                          mem_rsp_ready,
  output logic [OUT_TAG_WIDTH:0]        pending_count,
  output logic                          tag_err
);

  localparam int CNT_W = OUT_TAG_WIDTH + 1;

  logic [NUM_OUTSTANDING-1:0] valid_q, valid_d;
  logic [IN_TAG_WIDTH-1:0]    tag_table_q [NUM_OUTSTANDING];
  logic [IN_TAG_WIDTH-1:0]    tag_table_d [NUM_OUTSTANDING];
  logic                       rsp_valid_q, rsp_valid_d;
  logic [DATA_SIZE*8-1:0]     rsp_data_q, rsp_data_d;
  logic [IN_TAG_WIDTH-1:0]    rsp_tag_q, rsp_tag_d;
  logic                       tag_err_q, tag_err_d;

  logic                       full;
  logic                       slot_gate;
  logic [OUT_TAG_WIDTH-1:0]   alloc_slot;
  logic                       rd_fire;
  logic                       mem_rsp_fire;
  logic [CNT_W-1:0]           pending;

  assign full = &valid_q;

  // Lowest free slot from the registered bitmap, so a same-cycle free is not reused
  always_comb begin
    alloc_slot = '0;
    for (int i = NUM_OUTSTANDING - 1; i >= 0; i--) begin
      if (!valid_q[i]) alloc_slot = i[OUT_TAG_WIDTH-1:0];
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < NUM_OUTSTANDING; i++) begin
      pending = pending + CNT_W'(valid_q[i]);
    end
  end

  // Writes never consume a slot, so only reads are throttled by the table
  assign slot_gate      = core_req_rw || !full;
  assign mem_req_valid  = core_req_valid && slot_gate;
  assign core_req_ready = mem_req_ready && slot_gate;
  assign mem_req_rw     = core_req_rw;
  assign mem_req_addr   = core_req_addr;
  assign mem_req_data   = core_req_data;
  assign mem_req_byteen = core_req_byteen;
  assign mem_req_flags  = core_req_flags;
  assign mem_req_tag    = core_req_rw ? '0 : alloc_slot;

  assign rd_fire       = core_req_valid && core_req_ready && !core_req_rw;
  assign mem_rsp_ready = !rsp_valid_q || core_rsp_ready;
  assign mem_rsp_fire  = mem_rsp_valid && mem_rsp_ready;

  always_comb begin
    valid_d     = valid_q;
    tag_table_d = tag_table_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_tag_d   = rsp_tag_q;
    tag_err_d   = tag_err_q;
    // Free before allocate: a bogus response aimed at the slot being allocated must not cancel it
    if (mem_rsp_fire) begin
      valid_d[mem_rsp_tag] = 1'b0;
      rsp_valid_d          = 1'b1;
      rsp_data_d           = mem_rsp_data;
      rsp_tag_d            = tag_table_q[mem_rsp_tag];
      if (!valid_q[mem_rsp_tag]) tag_err_d = 1'b1;
    end else if (core_rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
    if (rd_fire) begin
      valid_d[alloc_slot]     = 1'b1;
      tag_table_d[alloc_slot] = core_req_tag;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q     <= '0;
      rsp_valid_q <= 1'b0;
      tag_err_q   <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      rsp_valid_q <= rsp_valid_d;
      tag_err_q   <= tag_err_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_table_q <= tag_table_d;
    rsp_data_q  <= rsp_data_d;
    rsp_tag_q   <= rsp_tag_d;
  end

  assign core_rsp_valid = rsp_valid_q;
  assign core_rsp_data  = rsp_data_q;
  assign core_rsp_tag   = rsp_tag_q;
  assign pending_count  = pending;
  assign tag_err        = tag_err_q;

endmodule

// File: tb/tb_vx_mem_tag_remap.sv
// Scoreboard bench for vx_mem_tag_remap: a reference slot model predicts tags and
// response contents; expected responses are queued on mem_rsp fire and popped on core_rsp fire.
module tb_vx_mem_tag_remap;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_req_valid, core_req_rw;
  logic [29:0] core_req_addr;
  logic [31:0] core_req_data;
  logic [3:0]  core_req_byteen;
  logic [0:0]  core_req_flags;
  logic [7:0]  core_req_tag;
  logic        core_req_ready;
  logic        core_rsp_valid;
  logic [31:0] core_rsp_data;
  logic [7:0]  core_rsp_tag;
  logic        core_rsp_ready;
  logic        mem_req_valid, mem_req_rw;
  logic [29:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic [3:0]  mem_req_byteen;
  logic [0:0]  mem_req_flags;
  logic [1:0]  mem_req_tag;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic [1:0]  mem_rsp_tag;
  logic        mem_rsp_ready;
  logic [2:0]  pending_count;
  logic        tag_err;

  vx_mem_tag_remap dut (
    .clk(clk), .reset(reset),
    .core_req_valid(core_req_valid), .core_req_rw(core_req_rw), .core_req_addr(core_req_addr),
    .core_req_data(core_req_data), .core_req_byteen(core_req_byteen), .core_req_flags(core_req_flags),
    .core_req_tag(core_req_tag), .core_req_ready(core_req_ready),
    .core_rsp_valid(core_rsp_valid), .core_rsp_data(core_rsp_data), .core_rsp_tag(core_rsp_tag),
    .core_rsp_ready(core_rsp_ready),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_byteen(mem_req_byteen), .mem_req_flags(mem_req_flags),
    .mem_req_tag(mem_req_tag), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_tag(mem_rsp_tag),
    .mem_rsp_ready(mem_rsp_ready), .pending_count(pending_count), .tag_err(tag_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  tag;
    logic [31:0] data;
  } exp_t;

  exp_t       sb_q [$];
  int         total = 0;
  int         bad = 0;
  logic [3:0] m_busy;
  logic [7:0] m_tbl [4];
  logic       m_err;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int m_alloc();
    for (int i = 0; i < 4; i++) if (!m_busy[i]) return i;
    return -1;
  endfunction

  function automatic logic [2:0] m_count();
    logic [2:0] c = '0;
    for (int i = 0; i < 4; i++) c = c + {2'b0, m_busy[i]};
    return c;
  endfunction

  // Core response monitor: inputs change just after posedge, so negedge sees the next edge's handshake
  always @(negedge clk) begin
    if (!reset && core_rsp_valid && core_rsp_ready) begin
      if (sb_q.size() == 0) begin
        chk("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("rsp_tag", {56'd0, core_rsp_tag}, {56'd0, e.tag});
        chk("rsp_data", {32'd0, core_rsp_data}, {32'd0, e.data});
      end
    end
  end

  // Issue one read that the model says must be accepted, checking the pass-through fields
  task automatic do_read(input logic [7:0] tag);
    int s;
    core_req_valid  = 1'b1;
    core_req_rw     = 1'b0;
    core_req_tag    = tag;
    core_req_addr   = 30'($urandom);
    core_req_data   = $urandom;
    core_req_byteen = 4'($urandom);
    core_req_flags  = 1'($urandom);
    #1;
    s = m_alloc();
    chk("rd_ready", {63'd0, core_req_ready}, 64'd1);
    chk("rd_valid", {63'd0, mem_req_valid}, 64'd1);
    chk("rd_tag", {62'd0, mem_req_tag}, 64'(s));
    chk("rd_addr", {34'd0, mem_req_addr}, {34'd0, core_req_addr});
    chk("rd_byteen", {60'd0, mem_req_byteen, mem_req_flags, mem_req_rw},
        {60'd0, core_req_byteen, core_req_flags, 1'b0});
    m_busy[s] = 1'b1;
    m_tbl[s]  = tag;
    tick();
    core_req_valid = 1'b0;
  endtask

  // Memory returns a response on a slot; expected core response is queued when it fires
  task automatic respond(input logic [1:0] slot, input logic [31:0] data);
    exp_t e;
    mem_rsp_valid = 1'b1;
    mem_rsp_tag   = slot;
    mem_rsp_data  = data;
    #1;
    chk("mrsp_ready", {63'd0, mem_rsp_ready}, 64'd1);
    e.tag  = m_tbl[slot];
    e.data = data;
    sb_q.push_back(e);
    if (!m_busy[slot]) m_err = 1'b1;
    m_busy[slot] = 1'b0;
    tick();
    mem_rsp_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    core_req_valid = 0; core_req_rw = 0; core_req_addr = 0; core_req_data = 0;
    core_req_byteen = 0; core_req_flags = 0; core_req_tag = 0;
    core_rsp_ready = 1; mem_req_ready = 1;
    mem_rsp_valid = 0; mem_rsp_data = 0; mem_rsp_tag = 0;
    m_busy = '0; m_err = 0;
    for (int i = 0; i < 4; i++) m_tbl[i] = '0;
    #1;
    chk("rst_pending", {61'd0, pending_count}, 64'd0);
    chk("rst_rspv", {63'd0, core_rsp_valid}, 64'd0);
    chk("rst_mrsp_ready", {63'd0, mem_rsp_ready}, 64'd1);
    chk("rst_err", {63'd0, tag_err}, 64'd0);
    mem_req_ready = 1'b0;
    #1;
    chk("rst_req_ready_lo", {63'd0, core_req_ready}, 64'd0);
    mem_req_ready = 1'b1;
    #1;
    chk("rst_req_ready_hi", {63'd0, core_req_ready}, 64'd1);
    tick(); tick();
    reset = 1'b0;
    tick();

    // single read, response 3 cycles later
    do_read(8'hA5);
    chk("p1_pending", {61'd0, pending_count}, 64'd1);
    tick(); tick();
    respond(2'd0, 32'hDEADBEEF);
    chk("p1_rspv", {63'd0, core_rsp_valid}, 64'd1);
    chk("p1_pending0", {61'd0, pending_count}, 64'd0);
    tick();

    // fill all slots, fifth read stalls
    for (int i = 0; i < 4; i++) do_read(8'h10 + 8'(i));
    chk("full_pending", {61'd0, pending_count}, 64'd4);
    core_req_valid = 1'b1; core_req_rw = 1'b0; core_req_tag = 8'h14;
    #1;
    chk("full_ready", {63'd0, core_req_ready}, 64'd0);
    chk("full_mvalid", {63'd0, mem_req_valid}, 64'd0);
    tick();
    // freeing slot 2 must not open the request path in the same cycle
    mem_rsp_valid = 1'b1; mem_rsp_tag = 2'd2; mem_rsp_data = 32'h2222_0002;
    #1;
    chk("free_same_cycle", {63'd0, core_req_ready}, 64'd0);
    respond(2'd2, 32'h2222_0002);
    do_read(8'h14);
    chk("refill_pending", {61'd0, pending_count}, 64'd4);
    respond(2'd3, 32'h3333_0003);
    respond(2'd0, 32'h0000_0010);
    respond(2'd1, 32'h1111_0001);
    respond(2'd2, 32'h2222_0014);
    tick();
    chk("ooo_pending", {61'd0, pending_count}, 64'd0);

    // writes pass while full
    for (int i = 0; i < 4; i++) do_read(8'h20 + 8'(i));
    for (int i = 0; i < 3; i++) begin
      core_req_valid = 1'b1; core_req_rw = 1'b1;
      core_req_data = $urandom; core_req_tag = 8'hEE;
      mem_req_ready = (i != 1);
      #1;
      chk("wr_mvalid", {63'd0, mem_req_valid}, 64'd1);
      chk("wr_ready", {63'd0, core_req_ready}, {63'd0, (i != 1)});
      chk("wr_tag", {62'd0, mem_req_tag}, 64'd0);
      chk("wr_data", {32'd0, mem_req_data}, {32'd0, core_req_data});
      tick();
    end
    core_req_valid = 1'b0; core_req_rw = 1'b0; mem_req_ready = 1'b1;
    #1;
    chk("wr_pending", {61'd0, pending_count}, 64'd4);
    tick(); tick();

    // backpressure: first response held, second waits
    core_rsp_ready = 1'b0;
    respond(2'd0, 32'hAAAA_0000);
    mem_rsp_valid = 1'b1; mem_rsp_tag = 2'd1; mem_rsp_data = 32'hBBBB_0001;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_mrsp_ready", {63'd0, mem_rsp_ready}, 64'd0);
      chk("bp_hold_tag", {56'd0, core_rsp_tag}, 64'h20);
      chk("bp_hold_data", {32'd0, core_rsp_data}, 64'hAAAA_0000);
      tick();
    end
    core_rsp_ready = 1'b1;
    respond(2'd1, 32'hBBBB_0001);
    respond(2'd2, 32'hCCCC_0002);
    respond(2'd3, 32'hDDDD_0003);
    tick();
    chk("bp_pending", {61'd0, pending_count}, 64'd0);

    // response to an unallocated slot
    respond(2'd1, 32'h0BAD_0001);
    chk("err_set", {63'd0, tag_err}, {63'd0, m_err});
    chk("err_pending", {61'd0, pending_count}, 64'd0);
    tick(); tick();
    chk("err_sticky", {63'd0, tag_err}, 64'd1);

    // reset with reads outstanding and a held response
    for (int i = 0; i < 3; i++) do_read(8'h30 + 8'(i));
    core_rsp_ready = 1'b0;
    respond(2'd2, 32'h5555_0002);
    chk("pre_rst_rspv", {63'd0, core_rsp_valid}, 64'd1);
    chk("pre_rst_pending", {61'd0, pending_count}, {61'd0, m_count()});
    reset = 1'b1;
    #1;
    chk("mid_rst_pending", {61'd0, pending_count}, 64'd0);
    chk("mid_rst_rspv", {63'd0, core_rsp_valid}, 64'd0);
    chk("mid_rst_err", {63'd0, tag_err}, 64'd0);
    sb_q.delete();
    m_busy = '0; m_err = 1'b0;
    tick();
    reset = 1'b0;
    core_rsp_ready = 1'b1;
    tick();
    respond(2'd1, 32'h1A7E_0001);
    chk("late_err", {63'd0, tag_err}, {63'd0, m_err});
    tick(); tick();
    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
